regfile_wb_queue: RTL and testbench

Write-side front end of the register file. Collects results from the ALU and memory pipelines over valid/ready handshakes and buffers them in a small in-order queue. Drains exactly one result per cycle onto the register file's single write port (`reg_w_ctrl`/`reg_w`/`w_data`). Optionally exposes a bypass lookup so operand readers can see results that are queued but not yet written.

---
 rtl/regfile_wb_queue_pkg.sv | 15 +
 rtl/regfile_wb_queue_fifo.sv | 67 ++++++
 rtl/regfile_wb_queue.sv | 98 +++++++++
 tb/tb_regfile_wb_queue.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_queue_pkg.sv
// Shared types for the register-file writeback queue (package common).
// Optional bypass lookup is enabled with the WB_BYPASS_EN macro.
package common;

  typedef logic [4:0]  u5;
  typedef logic [63:0] u64;

  typedef struct packed {
    u5  rd;
    u64 data;
  } wb_entry_t;

  localparam int WB_DEPTH = 4;

endpackage

// File: rtl/regfile_wb_queue_fifo.sv
// In-order circular buffer with ordered dual push and single pop.
// With WB_BYPASS_EN the raw storage and head pointer are exported for lookup.
module wb_fifo
  import common::*;
#(
  parameter int DEPTH = WB_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push0_i,
  input  wb_entry_t       entry0_i,
  input  logic            push1_i,
  input  wb_entry_t       entry1_i,
  input  logic            pop_i,
  output wb_entry_t       head_o,
  output logic [CW-1:0]   count_o
`ifdef WB_BYPASS_EN
  ,
  output wb_entry_t       entries_o [DEPTH],
  output logic [PW-1:0]   headPtr_o
`endif
);

  wb_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [PW-1:0]     tail1;
  logic [CW-1:0]     count_q, count_d;

  // The second push lands behind the first when both are present.
  always_comb begin
    tail1   = tail_q + PW'(push0_i);
    tail_d  = tail_q + PW'(push0_i) + PW'(push1_i);
    head_d  = head_q + PW'(pop_i);
    count_d = count_q - CW'(pop_i) + CW'(push0_i) + CW'(push1_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push0_i) mem_q[tail_q] <= entry0_i;
      if (push1_i) mem_q[tail1]  <= entry1_i;
    end
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

`ifdef WB_BYPASS_EN
  assign entries_o = mem_q;
  assign headPtr_o = head_q;
`endif

endmodule

// File: rtl/regfile_wb_queue.sv
// Writeback front end: accepts ALU/memory results and drains one per cycle to the RF.
// Define WB_BYPASS_EN to add the queued-result bypass lookup ports.
module regfile_wb_queue
  import common::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [4:0]              mem_rd,
  input  logic [63:0]             mem_data,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [4:0]              alu_rd,
  input  logic [63:0]             alu_data,
  output logic                    wb_en,
  output logic [4:0]              wb_reg,
  output logic [63:0]             wb_data,
  output logic [$clog2(DEPTH):0]  pending
`ifdef WB_BYPASS_EN
  ,
  input  logic [4:0]              byp_reg,
  output logic                    byp_hit,
  output logic [63:0]             byp_data
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic          notEmpty;
  logic          memEnq, aluEnq;
  wb_entry_t     memEntry, aluEntry, headEntry;

`ifdef WB_BYPASS_EN
  wb_entry_t     entries [DEPTH];
  logic [PW-1:0] headPtr;
`endif

  // The head slot is always drained this cycle, so it already counts as free.
  always_comb begin
    notEmpty  = (count != '0);
    free      = CW'(DEPTH) - count + CW'(notEmpty);
    mem_ready = (free >= CW'(1));
    alu_ready = (free >= (mem_valid ? CW'(2) : CW'(1)));
    memEnq    = mem_valid && mem_ready && (mem_rd != '0) && !rst;
    aluEnq    = alu_valid && alu_ready && (alu_rd != '0) && !rst;
    memEntry  = '{rd: mem_rd, data: mem_data};
    aluEntry  = '{rd: alu_rd, data: alu_data};
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push0_i  (memEnq),
    .entry0_i (memEntry),
    .push1_i  (aluEnq),
    .entry1_i (aluEntry),
    .pop_i    (notEmpty),
    .head_o   (headEntry),
    .count_o  (count)
`ifdef WB_BYPASS_EN
    ,
    .entries_o(entries),
    .headPtr_o(headPtr)
`endif
  );

  always_comb begin
    wb_en   = notEmpty;
    wb_reg  = notEmpty ? headEntry.rd   : '0;
    wb_data = notEmpty ? headEntry.data : '0;
    pending = count;
  end

`ifdef WB_BYPASS_EN
  logic [PW-1:0] idx;

  // Walk oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = headPtr + PW'(i);
      if ((CW'(i) < count) && (byp_reg != '0) && (entries[idx].rd == byp_reg)) begin
        byp_hit  = 1'b1;
        byp_data = entries[idx].data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed/random bench for regfile_wb_queue with a queue scoreboard model.
// Bypass checks are compiled in when WB_BYPASS_EN is defined.
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_rd;
  logic [63:0] mem_data;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [63:0] wb_data;
  logic [2:0]  pending;
  logic [4:0]  byp_reg;
  logic        byp_hit;
  logic [63:0] byp_data;

  ent_t sbQ[$];
  int   total = 0;
  int   bad   = 0;

  regfile_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .wb_en     (wb_en),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .pending   (pending)
`ifdef WB_BYPASS_EN
    ,
    .byp_reg   (byp_reg),
    .byp_hit   (byp_hit),
    .byp_data  (byp_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    int   n;
    int   freeSlots;
    logic expHit;
    logic [63:0] expByp;
    n         = sbQ.size();
    freeSlots = DEPTH - n + ((n != 0) ? 1 : 0);
    checkVal("wb_en",     64'(wb_en),     64'(n != 0));
    checkVal("wb_reg",    64'(wb_reg),    (n != 0) ? 64'(sbQ[0].rd) : 64'd0);
    checkVal("wb_data",   wb_data,        (n != 0) ? sbQ[0].data : 64'd0);
    checkVal("pending",   64'(pending),   64'(n));
    checkVal("mem_ready", 64'(mem_ready), 64'(freeSlots >= 1));
    checkVal("alu_ready", 64'(alu_ready), 64'(freeSlots >= (mem_valid ? 2 : 1)));
    expHit = 1'b0;
    expByp = '0;
    for (int i = 0; i < n; i++) begin
      if (byp_reg != 5'd0 && sbQ[i].rd == byp_reg) begin
        expHit = 1'b1;
        expByp = sbQ[i].data;
      end
    end
`ifdef WB_BYPASS_EN
    checkVal("byp_hit",  64'(byp_hit), 64'(expHit));
    checkVal("byp_data", byp_data,     expByp);
`endif
  endtask

  // One clock of stimulus: drive, check before the edge, then advance the model.
  task automatic applyStimulus(input logic r, input logic mv, input logic [4:0] mrd,
                               input logic [63:0] md, input logic av, input logic [4:0] ard,
                               input logic [63:0] ad, input logic [4:0] br, input bit chk);
    int   n;
    int   freeSlots;
    logic mr, ar;
    rst = r; mem_valid = mv; mem_rd = mrd; mem_data = md;
    alu_valid = av; alu_rd = ard; alu_data = ad; byp_reg = br;
    @(negedge clk);
    if (chk) checkOutput();
    n         = sbQ.size();
    freeSlots = DEPTH - n + ((n != 0) ? 1 : 0);
    mr        = (freeSlots >= 1);
    ar        = (freeSlots >= (mv ? 2 : 1));
    if (r) begin
      sbQ.delete();
    end else begin
      if (n != 0) void'(sbQ.pop_front());
      if (mv && mr && mrd != 5'd0) sbQ.push_back('{rd: mrd, data: md});
      if (av && ar && ard != 5'd0) sbQ.push_back('{rd: ard, data: ad});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles, input logic [4:0] br);
    for (int i = 0; i < cycles; i++)
      applyStimulus(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, br, 1'b1);
  endtask

  initial begin
    rst = 1'b1; mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0; byp_reg = '0;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 5'd0, 1'b0);
    idle(1, 5'd0);

    applyStimulus(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 64'h1234, 5'd3, 1'b1);
    idle(2, 5'd3);

    applyStimulus(1'b0, 1'b1, 5'd5, 64'hAA, 1'b1, 5'd5, 64'hBB, 5'd5, 1'b1);
    idle(3, 5'd5);

    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 1'b1, 5'(2 * i + 1), 64'(16'hA000 + i), 1'b1, 5'(2 * i + 2),
                    64'(16'hB000 + i), 5'(i + 1), 1'b1);
    idle(6, 5'd2);

    applyStimulus(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'hFF, 5'd0, 1'b1);
    idle(2, 5'd0);

    applyStimulus(1'b0, 1'b1, 5'd7, 64'h70, 1'b1, 5'd8, 64'h80, 5'd7, 1'b1);
    applyStimulus(1'b0, 1'b1, 5'd9, 64'h90, 1'b1, 5'd7, 64'h71, 5'd7, 1'b1);
    applyStimulus(1'b1, 1'b1, 5'd4, 64'h40, 1'b1, 5'd6, 64'h60, 5'd7, 1'b1);
    idle(3, 5'd7);

    for (int i = 0; i < 40; i++)
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 64'($urandom),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 64'($urandom),
                    5'($urandom_range(0, 7)), 1'b1);
    idle(6, 5'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
